// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution unit: condition-code values,
// the 2-bit direction-counter encoding and its saturating step function.
package branch_resolve_unit_pkg;

   localparam logic [3:0] COND_NEVER = 4'd0;
   localparam logic [3:0] COND_EQ    = 4'd1;
   localparam logic [3:0] COND_NE    = 4'd2;
   localparam logic [3:0] COND_LT    = 4'd3;
   localparam logic [3:0] COND_GE    = 4'd4;
   localparam logic [3:0] COND_LE    = 4'd5;
   localparam logic [3:0] COND_GT    = 4'd6;
   localparam logic [3:0] COND_CS    = 4'd7;
   localparam logic [3:0] COND_CC    = 4'd8;
   localparam logic [3:0] COND_VS    = 4'd9;
   localparam logic [3:0] COND_AL    = 4'd10;

   // Direction counter: the MSB is the predicted direction.
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   localparam ctr_t CTR_RESET = CTR_WNT;

   // Move a counter one step toward taken (up=1) or not-taken, sticking at the ends.
   function automatic ctr_t ctr_step(input ctr_t cur, input logic up);
      ctr_t nxt;
      nxt = cur;
      if (up) begin
         case (cur)
            CTR_SNT: nxt = CTR_WNT;
            CTR_WNT: nxt = CTR_WT;
            default: nxt = CTR_ST;
         endcase
      end else begin
         case (cur)
            CTR_ST:  nxt = CTR_WT;
            CTR_WT:  nxt = CTR_WNT;
            default: nxt = CTR_SNT;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational condition-code evaluator: decides the actual branch direction
// from a 4-bit condition code and the ALU flags. Unused codes read as not taken.
module branch_cond_eval
   import branch_resolve_unit_pkg::*;
#(
   parameter bit LT_USE_OF = 1'b1
) (
   input  logic [3:0] cond,
   input  logic       sf,
   input  logic       zf,
   input  logic       of,
   input  logic       cf,
   output logic       taken
);

   logic lt;

   // Signed less-than either honours overflow or trusts the sign flag alone.
   assign lt = LT_USE_OF ? (sf ^ of) : sf;

   // Decode the condition code into a taken/not-taken decision.
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = zf;
         COND_NE: taken = ~zf;
         COND_LT: taken = lt;
         COND_GE: taken = ~lt;
         COND_LE: taken = lt | zf;
         COND_GT: taken = ~(lt | zf);
         COND_CS: taken = cf;
         COND_CC: taken = ~cf;
         COND_VS: taken = of;
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution in EX: evaluates the branch condition, trains a table of
// 2-bit direction counters, reports a registered resolution one cycle later
// and counts mispredicts (saturating).
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int IDX_W     = 6,
   parameter int CNT_W     = 16,
   parameter bit LT_USE_OF = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] if_idx,
   output logic             if_pred_taken,
   input  logic             ex_valid,
   input  logic [IDX_W-1:0] ex_idx,
   input  logic [3:0]       ex_cond,
   input  logic             ex_pred_taken,
   input  logic             sf,
   input  logic             zf,
   input  logic             of,
   input  logic             cf,
   input  logic             flush,
   output logic             res_valid,
   output logic             res_taken,
   output logic             res_mispredict,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int DEPTH = 2 ** IDX_W;

   ctr_t pred_table [DEPTH];
   ctr_t if_entry;
   logic taken;
   logic accept;
   logic mispredict;

   branch_cond_eval #(
      .LT_USE_OF(LT_USE_OF)
   ) u_cond (
      .cond (ex_cond),
      .sf   (sf),
      .zf   (zf),
      .of   (of),
      .cf   (cf),
      .taken(taken)
   );

   assign accept     = ex_valid & ~flush;
   assign mispredict = taken ^ ex_pred_taken;

   // Fetch-side read returns the stored value; an update in the same cycle is not bypassed.
   assign if_entry      = pred_table[if_idx];
   assign if_pred_taken = (if_entry == CTR_WT) || (if_entry == CTR_ST);

   // Train the counter of every accepted branch, whatever its condition code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pred_table[i] <= CTR_RESET;
         end
      end else if (accept) begin
         pred_table[ex_idx] <= ctr_step(pred_table[ex_idx], taken);
      end
   end

   // Register the resolution; a dropped slot presents all zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         res_mispredict <= 1'b0;
      end else begin
         res_valid      <= accept;
         res_taken      <= accept & taken;
         res_mispredict <= accept & mispredict;
      end
   end

   // Count accepted mispredicts, holding at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_cnt <= '0;
      end else if (accept && mispredict && (mispredict_cnt != '1)) begin
         mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a table of directed vectors
// with hand-derived expectations, an asynchronous-reset sequence, then a
// randomized run checked against a behavioural model of the predictor.
module tb_branch_resolve_unit;

   localparam int IDX_W = 6;
   localparam int CNT_W = 3;
   localparam int DEPTH = 64;
   localparam int CMAX  = 7;

   logic             clk;
   logic             rst;
   logic [IDX_W-1:0] if_idx;
   logic             if_pred_taken;
   logic             ex_valid;
   logic [IDX_W-1:0] ex_idx;
   logic [3:0]       ex_cond;
   logic             ex_pred_taken;
   logic             sf, zf, of, cf;
   logic             flush;
   logic             res_valid;
   logic             res_taken;
   logic             res_mispredict;
   logic [CNT_W-1:0] mispredict_cnt;

   int errors;
   int checks;

   int model_tab [DEPTH];
   int model_cnt;

   typedef struct {
      logic       v;
      logic       fl;
      logic       pred;
      logic [5:0] idx;
      logic [3:0] cond;
      logic [3:0] flags;
      logic [5:0] rd_idx;
      logic       e_if;
      logic       e_rv;
      logic       e_rt;
      logic       e_rm;
      int         e_cnt;
   } vec_t;

   vec_t vecs[$];

   branch_resolve_unit #(
      .IDX_W(IDX_W),
      .CNT_W(CNT_W),
      .LT_USE_OF(1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_idx        (if_idx),
      .if_pred_taken (if_pred_taken),
      .ex_valid      (ex_valid),
      .ex_idx        (ex_idx),
      .ex_cond       (ex_cond),
      .ex_pred_taken (ex_pred_taken),
      .sf            (sf),
      .zf            (zf),
      .of            (of),
      .cf            (cf),
      .flush         (flush),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .res_mispredict(res_mispredict),
      .mispredict_cnt(mispredict_cnt)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Architectural meaning of each condition code, flags given as {sf,zf,of,cf}
   function automatic logic ref_taken(input logic [3:0] cond, input logic [3:0] flags);
      logic s, z, o, c, lt;
      s = flags[3];
      z = flags[2];
      o = flags[1];
      c = flags[0];
      lt = s ^ o;
      case (cond)
         4'd1:    return z;
         4'd2:    return !z;
         4'd3:    return lt;
         4'd4:    return !lt;
         4'd5:    return lt || z;
         4'd6:    return !(lt || z);
         4'd7:    return c;
         4'd8:    return !c;
         4'd9:    return o;
         4'd10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic fl, input logic pred,
                                 input logic [5:0] idx, input logic [3:0] cond,
                                 input logic [3:0] flags, input logic [5:0] rd_idx);
      ex_valid      = v;
      flush         = fl;
      ex_pred_taken = pred;
      ex_idx        = idx;
      ex_cond       = cond;
      {sf, zf, of, cf} = flags;
      if_idx        = rd_idx;
   endtask

   task automatic add_vec(input logic v, input logic fl, input logic pred,
                          input logic [5:0] idx, input logic [3:0] cond,
                          input logic [3:0] flags, input logic [5:0] rd_idx,
                          input logic e_if, input logic e_rv, input logic e_rt,
                          input logic e_rm, input int e_cnt);
      vec_t t;
      t.v = v; t.fl = fl; t.pred = pred; t.idx = idx; t.cond = cond;
      t.flags = flags; t.rd_idx = rd_idx; t.e_if = e_if; t.e_rv = e_rv;
      t.e_rt = e_rt; t.e_rm = e_rm; t.e_cnt = e_cnt;
      vecs.push_back(t);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_tab[i] = 1;
      model_cnt = 0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0, 6'd0);
      @(negedge clk);
      do_reset();

      // Directed vectors: v fl pred idx cond {sf,zf,of,cf} rd | if rv rt rm cnt
      add_vec(1, 0, 0,  5,  1, 4'b0100,  5,  0, 1, 1, 1, 1);
      add_vec(0, 0, 0,  0,  0, 4'b0000,  5,  1, 0, 0, 0, 1);
      add_vec(1, 0, 0, 10,  3, 4'b1010, 10,  0, 1, 0, 0, 1);
      add_vec(1, 0, 0, 11,  3, 4'b1000, 11,  0, 1, 1, 1, 2);
      add_vec(1, 0, 1, 12,  6, 4'b0100, 11,  1, 1, 0, 1, 3);
      add_vec(1, 0, 1, 13,  8, 4'b0000, 12,  0, 1, 1, 0, 3);
      add_vec(1, 0, 0, 14, 13, 4'b1111, 13,  1, 1, 0, 0, 3);
      add_vec(1, 0, 1,  2, 10, 4'b0000,  2,  0, 1, 1, 0, 3);
      add_vec(1, 0, 1,  2, 10, 4'b0000,  2,  1, 1, 1, 0, 3);
      add_vec(1, 0, 1,  2, 10, 4'b0000,  2,  1, 1, 1, 0, 3);
      add_vec(1, 0, 1,  2, 10, 4'b0000,  2,  1, 1, 1, 0, 3);
      add_vec(1, 0, 1,  2, 10, 4'b0000,  2,  1, 1, 1, 0, 3);
      add_vec(1, 0, 1,  2,  0, 4'b0000,  2,  1, 1, 0, 1, 4);
      add_vec(0, 0, 0,  0,  0, 4'b0000,  2,  1, 0, 0, 0, 4);
      add_vec(1, 1, 0,  3, 10, 4'b0000,  3,  0, 0, 0, 0, 4);
      add_vec(0, 0, 0,  0,  0, 4'b0000,  3,  0, 0, 0, 0, 4);
      add_vec(1, 0, 0,  7, 10, 4'b0000,  7,  0, 1, 1, 1, 5);
      add_vec(0, 0, 0,  0,  0, 4'b0000,  7,  1, 0, 0, 0, 5);
      add_vec(1, 0, 0, 20, 10, 4'b0000, 20,  0, 1, 1, 1, 6);
      add_vec(1, 0, 0, 20, 10, 4'b0000, 20,  1, 1, 1, 1, 7);
      add_vec(1, 0, 0, 20, 10, 4'b0000, 20,  1, 1, 1, 1, 7);
      add_vec(1, 0, 0, 20, 10, 4'b0000, 20,  1, 1, 1, 1, 7);

      foreach (vecs[k]) begin
         apply_stimulus(vecs[k].v, vecs[k].fl, vecs[k].pred, vecs[k].idx,
                        vecs[k].cond, vecs[k].flags, vecs[k].rd_idx);
         #1;
         check_output($sformatf("vec%0d if_pred_taken", k), 32'(if_pred_taken), 32'(vecs[k].e_if));
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("vec%0d res_valid", k), 32'(res_valid), 32'(vecs[k].e_rv));
         check_output($sformatf("vec%0d res_taken", k), 32'(res_taken), 32'(vecs[k].e_rt));
         check_output($sformatf("vec%0d res_mispredict", k), 32'(res_mispredict), 32'(vecs[k].e_rm));
         check_output($sformatf("vec%0d mispredict_cnt", k), 32'(mispredict_cnt), 32'(vecs[k].e_cnt));
      end

      // Asynchronous reset between edges while a resolution is being presented
      apply_stimulus(1'b1, 1'b0, 1'b0, 6'd30, 4'd10, 4'b0000, 6'd30);
      @(posedge clk);
      @(negedge clk);
      check_output("pre-reset res_valid", 32'(res_valid), 32'd1);
      check_output("pre-reset res_mispredict", 32'(res_mispredict), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_output("async res_valid", 32'(res_valid), 32'd0);
      check_output("async res_taken", 32'(res_taken), 32'd0);
      check_output("async res_mispredict", 32'(res_mispredict), 32'd0);
      check_output("async mispredict_cnt", 32'(mispredict_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) model_tab[i] = 1;
      model_cnt = 0;
      ex_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if_idx = 6'(i);
         #1;
         check_output($sformatf("post-reset entry%0d", i), 32'(if_pred_taken), 32'd0);
      end
      @(negedge clk);

      // Randomized run against the behavioural model; a small index range forces collisions
      for (int n = 0; n < 2000; n++) begin
         logic       v, fl, pred, t, acc;
         logic [5:0] idx, rd;
         logic [3:0] cond, flags;
         logic       e_rv, e_rt, e_rm;
         v     = ($urandom_range(0, 3) != 0);
         fl    = ($urandom_range(0, 3) == 0);
         pred  = 1'($urandom);
         idx   = 6'($urandom_range(0, 7));
         rd    = ($urandom_range(0, 1) == 0) ? idx : 6'($urandom_range(0, 7));
         cond  = 4'($urandom);
         flags = 4'($urandom);
         apply_stimulus(v, fl, pred, idx, cond, flags, rd);
         #1;
         check_output("rand if_pred_taken", 32'(if_pred_taken), 32'(model_tab[rd] >= 2));
         acc  = v && !fl;
         t    = ref_taken(cond, flags);
         e_rv = acc;
         e_rt = acc && t;
         e_rm = acc && (t != pred);
         if (acc) begin
            if (t) model_tab[idx] = (model_tab[idx] < 3) ? model_tab[idx] + 1 : 3;
            else   model_tab[idx] = (model_tab[idx] > 0) ? model_tab[idx] - 1 : 0;
         end
         if (e_rm && model_cnt < CMAX) model_cnt++;
         @(posedge clk);
         @(negedge clk);
         check_output("rand res_valid", 32'(res_valid), 32'(e_rv));
         check_output("rand res_taken", 32'(res_taken), 32'(e_rt));
         check_output("rand res_mispredict", 32'(res_mispredict), 32'(e_rm));
         check_output("rand mispredict_cnt", 32'(mispredict_cnt), 32'(model_cnt));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution block in EX. Evaluates a 4-bit condition code against the ALU flags and updates a table of 2-bit saturating direction predictors.
- Reports a registered taken/mispredict result one cycle later to the fetch/flush logic, and keeps a saturating mispredict counter.
- Generalises the 3-bit combinational condition decoder with unsigned/overflow conditions, prediction, and pipelining.

Parameters:
- IDX_W, 6, predictor index width; table depth = 2**IDX_W entries.
- CNT_W, 16, width of the mispredict statistics counter.
- LT_USE_OF, 1, 1: signed less-than = sf^of; 0: signed less-than = sf.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- if_idx  in  IDX_W  fetch-stage predictor index (low PC bits).
- if_pred_taken  out  1  combinational; MSB of counter[if_idx].
- ex_valid  in  1  a branch/jump is in EX this cycle.
- ex_idx  in  IDX_W  predictor index of the EX branch.
- ex_cond  in  4  condition code.
- ex_pred_taken  in  1  prediction carried down the pipe with the branch.
- sf, zf, of, cf  in  1 each  ALU flags for the EX instruction.
- flush  in  1  squash the EX slot this cycle.
- res_valid  out  1  registered; a resolution is presented.
- res_taken  out  1  registered; actual direction.
- res_mispredict  out  1  registered; res_taken != prediction.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Condition codes:
  - 0 never; 1 EQ zf; 2 NE !zf.
  - 3 LT lt; 4 GE !lt; 5 LE lt|zf; 6 GT !(lt|zf).
  - 7 CS cf; 8 CC !cf; 9 VS of; 10 AL always.
  - 11-15 never (treated as not taken; no error).
  - lt = LT_USE_OF ? sf^of : sf.
- Condition evaluation is combinational. Define accept = ex_valid & !flush.
- Result pipeline, 1-cycle latency:
  - At each edge: res_valid <= accept, res_taken <= accept & taken, res_mispredict <= accept & (taken ^ ex_pred_taken).
  - When accept = 0, all three outputs are 0 next cycle.
- Predictor table:
  - Entries are 2-bit counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - On accept, counter[ex_idx] increments if taken, else decrements, saturating at 11 and 00.
  - Code 10 (AL) and codes 0/11-15 also update the table, for uniformity.
  - Flushed or invalid slots leave the table unchanged.
- Read/write collision: when if_idx == ex_idx in an updating cycle, if_pred_taken returns the pre-update value. There is no bypass.
- mispredict_cnt increments on every edge where accept and a mispredict coincide. It holds at all-ones and never wraps.
- Reset (asynchronous, at any time, including mid-resolution):
  - All table entries go to 01.
  - res_valid, res_taken, res_mispredict = 0; mispredict_cnt = 0.
  - A branch in EX during reset is dropped with no update.
- ex_pred_taken is taken as given; the block does not check it against its own table.

Decomposition:
- Shared package: condition-code localparams (COND_NEVER=0 … COND_AL=10) and counter-state constants (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST, CTR_RESET=CTR_WNT).
- One sub-module, branch_cond_eval: purely combinational; inputs cond, sf, zf, of, cf and LT_USE_OF; output taken. The table, result registers and statistics counter stay in the top.

Test Plan:
- Reset then read: rst pulse, if_idx=5 -> if_pred_taken=0. Then ex_valid=1, idx=5, cond=1, zf=1, pred=0 -> next cycle res_valid=1, res_taken=1, res_mispredict=1, mispredict_cnt=1. A subsequent read of idx 5 -> if_pred_taken=1.
- Condition sweep, LT_USE_OF=1: cond=3 with sf=1/of=1 -> not taken; sf=1/of=0 -> taken; cond=6 with zf=1 -> not taken; cond=8 with cf=0 -> taken; cond=13 -> not taken.
- Saturation: four taken updates on idx 2 -> counter 11. A fifth taken update keeps 11. One not-taken update -> 10, so if_pred_taken is still 1.
- Flush/collision:
  - ex_valid=1 with flush=1 -> res_valid=0 next cycle, table unchanged.
  - if_idx=ex_idx=7 during an update -> if_pred_taken shows the old value that cycle and the new value the next cycle.
- Async reset mid-stream: assert rst between edges while res_valid=1 -> outputs clear immediately, before the next edge. After release, every entry reads weak-NT.
- Counter saturation: CNT_W=3, force 9 mispredicts -> mispredict_cnt=7 and holds.
